// File: rtl/aes_keyram_pkg.sv
// Shared types, widths and schedule-length helper for the multi-buffer AES round-key store.
package aes_keyram_pkg;

   localparam int unsigned WR_W   = 64;
   localparam int unsigned RD_W   = 2 * WR_W;
   localparam int unsigned MAX_RK = 15;

   typedef enum logic [1:0] {
      AES128 = 2'd0,
      AES192 = 2'd1,
      AES256 = 2'd2
   } key_mode_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DROP = 2'd2
   } wr_state_t;

   // Round keys per schedule for a given key size.
   function automatic logic [3:0] nrk(input key_mode_t mode);
      case (mode)
         AES192:  nrk = 4'd13;
         AES256:  nrk = 4'd15;
         default: nrk = 4'd11;
      endcase
   endfunction

   // Raw key_mode input to schedule type; the reserved code behaves as AES-128.
   function automatic key_mode_t to_mode(input logic [1:0] m);
      case (m)
         2'd1:    to_mode = AES192;
         2'd2:    to_mode = AES256;
         default: to_mode = AES128;
      endcase
   endfunction

endpackage

// File: rtl/aes_keyram_bank.sv
// Simple dual-port RAM with registered read; one half (lo or hi) of every round key.
module aes_keyram_bank #(
   parameter int unsigned DEPTH = 60,
   parameter int unsigned AW    = 6,
   parameter int unsigned DW    = 64
) (
   input  logic          clk,
   input  logic          kill_n,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Read returns the pre-write contents when addresses collide.
   always_ff @(posedge clk or negedge kill_n) begin
      if (!kill_n) r_rdata <= '0;
      else         r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/aes_keyram_nbuf_switch.sv
// N-buffer AES round-key store: beat-wise loader into a free buffer, round-key reader on the
// active buffer, and round-robin switching to the next loaded buffer.
module aes_keyram_nbuf_switch #(
   parameter int unsigned NUM_BUF = 4,
   parameter int unsigned BUF_AW  = 2,
   parameter int unsigned MAX_RK  = aes_keyram_pkg::MAX_RK
) (
   input  logic                            clk,
   input  logic                            kill_n,
   input  logic                            en_wr,
   input  logic [aes_keyram_pkg::WR_W-1:0] key_round_wr,
   input  logic [BUF_AW-1:0]               wr_buf,
   input  logic [1:0]                      key_mode,
   input  logic                            key_ready,
   input  logic                            switch_key,
   output logic [aes_keyram_pkg::RD_W-1:0] key_round_rd,
   output logic [BUF_AW-1:0]               key_idx,
   output logic [3:0]                      rd_round,
   output logic                            last_round,
   output logic [NUM_BUF-1:0]              buf_valid,
   output logic                            wr_done,
   output logic                            wr_err
);
   import aes_keyram_pkg::*;

   localparam int unsigned DEPTH = NUM_BUF * MAX_RK;
   localparam int unsigned AW    = $clog2(DEPTH);

   wr_state_t           r_state,     w_state_nxt;
   logic [4:0]          r_cnt,       w_cnt_nxt;
   logic [BUF_AW-1:0]   r_tgt,       w_tgt_nxt;
   key_mode_t           r_lmode,     w_lmode_nxt;
   key_mode_t           r_buf_mode [NUM_BUF];
   key_mode_t           w_buf_mode_nxt [NUM_BUF];
   logic [NUM_BUF-1:0]  r_valid,     w_valid_nxt;
   logic [BUF_AW-1:0]   r_key_idx,   w_key_idx_nxt;
   logic [3:0]          r_rd_round,  w_rd_round_nxt;
   logic                r_last,      w_last_nxt;
   logic                r_wr_done,   w_wr_done_nxt;
   logic                r_wr_err,    w_wr_err_nxt;

   logic                w_we;
   logic [BUF_AW-1:0]   w_wbuf;
   logic [4:0]          w_wword;
   logic                w_sw_found;
   logic [BUF_AW-1:0]   w_sw_tgt;
   logic [BUF_AW-1:0]   w_cand;
   logic [AW-1:0]       w_waddr;
   logic [AW-1:0]       w_raddr;
   logic [WR_W-1:0]     w_rd_lo;
   logic [WR_W-1:0]     w_rd_hi;

   always_ff @(posedge clk or negedge kill_n) begin
      if (!kill_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_tgt      <= '0;
         r_lmode    <= AES128;
         r_buf_mode <= '{default: AES128};
         r_valid    <= '0;
         r_key_idx  <= '0;
         r_rd_round <= '0;
         r_last     <= 1'b0;
         r_wr_done  <= 1'b0;
         r_wr_err   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_tgt      <= w_tgt_nxt;
         r_lmode    <= w_lmode_nxt;
         r_buf_mode <= w_buf_mode_nxt;
         r_valid    <= w_valid_nxt;
         r_key_idx  <= w_key_idx_nxt;
         r_rd_round <= w_rd_round_nxt;
         r_last     <= w_last_nxt;
         r_wr_done  <= w_wr_done_nxt;
         r_wr_err   <= w_wr_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_tgt_nxt      = r_tgt;
      w_lmode_nxt    = r_lmode;
      w_buf_mode_nxt = r_buf_mode;
      w_valid_nxt    = r_valid;
      w_key_idx_nxt  = r_key_idx;
      w_rd_round_nxt = r_rd_round;
      w_wr_done_nxt  = 1'b0;
      w_wr_err_nxt   = 1'b0;
      w_we           = 1'b0;
      w_wbuf         = r_tgt;
      w_wword        = r_cnt;
      w_sw_found     = 1'b0;
      w_sw_tgt       = r_key_idx;
      w_cand         = r_key_idx;

      // First valid buffer after the active one, on pre-update flags.
      for (int unsigned i = 1; i < NUM_BUF; i++) begin
         w_cand = r_key_idx + BUF_AW'(i);
         if (!w_sw_found && r_valid[w_cand]) begin
            w_sw_found = 1'b1;
            w_sw_tgt   = w_cand;
         end
      end

      if (switch_key) begin
         if (w_sw_found) begin
            w_key_idx_nxt          = w_sw_tgt;
            w_rd_round_nxt         = 4'd0;
            w_valid_nxt[r_key_idx] = 1'b0;
         end
      end else if (key_ready) begin
         w_rd_round_nxt = (r_rd_round >= nrk(r_buf_mode[r_key_idx]) - 4'd1) ?
                          4'd0 : r_rd_round + 4'd1;
      end

      case (r_state)
         S_IDLE: begin
            if (en_wr) begin
               w_tgt_nxt   = wr_buf;
               w_lmode_nxt = to_mode(key_mode);
               w_cnt_nxt   = 5'd1;
               if (wr_buf == r_key_idx && r_valid[r_key_idx]) begin
                  w_state_nxt  = S_DROP;
                  w_wr_err_nxt = 1'b1;
               end else begin
                  w_valid_nxt[wr_buf] = 1'b0;
                  w_we                = 1'b1;
                  w_wbuf              = wr_buf;
                  w_wword             = 5'd0;
                  w_state_nxt         = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            if (en_wr) begin
               w_we      = 1'b1;
               w_cnt_nxt = r_cnt + 5'd1;
               if (r_cnt == {nrk(r_lmode), 1'b0} - 5'd1) begin
                  w_state_nxt           = S_IDLE;
                  w_valid_nxt[r_tgt]    = 1'b1;
                  w_buf_mode_nxt[r_tgt] = r_lmode;
                  w_wr_done_nxt         = 1'b1;
               end
            end
         end
         S_DROP: begin
            if (en_wr) begin
               w_cnt_nxt = r_cnt + 5'd1;
               if (r_cnt == {nrk(r_lmode), 1'b0} - 5'd1) w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      w_last_nxt = (w_rd_round_nxt == nrk(w_buf_mode_nxt[w_key_idx_nxt]) - 4'd1);
   end

   // Word 2k / 2k+1 are the low / high halves of round key k.
   assign w_waddr = AW'(w_wbuf) * AW'(MAX_RK) + AW'(w_wword[4:1]);
   assign w_raddr = AW'(r_key_idx) * AW'(MAX_RK) + AW'(r_rd_round);

   aes_keyram_bank #(.DEPTH(DEPTH), .AW(AW), .DW(WR_W)) u_bank_lo (
      .clk     (clk),
      .kill_n  (kill_n),
      .i_we    (w_we & ~w_wword[0]),
      .i_waddr (w_waddr),
      .i_wdata (key_round_wr),
      .i_raddr (w_raddr),
      .o_rdata (w_rd_lo)
   );

   aes_keyram_bank #(.DEPTH(DEPTH), .AW(AW), .DW(WR_W)) u_bank_hi (
      .clk     (clk),
      .kill_n  (kill_n),
      .i_we    (w_we & w_wword[0]),
      .i_waddr (w_waddr),
      .i_wdata (key_round_wr),
      .i_raddr (w_raddr),
      .o_rdata (w_rd_hi)
   );

   assign key_round_rd = {w_rd_hi, w_rd_lo};
   assign key_idx      = r_key_idx;
   assign rd_round     = r_rd_round;
   assign last_round   = r_last;
   assign buf_valid    = r_valid;
   assign wr_done      = r_wr_done;
   assign wr_err       = r_wr_err;

endmodule

// File: tb/tb_aes_keyram_nbuf_switch.sv
// Bench for the N-buffer AES key store: directed FIPS-197 loads plus randomized traffic,
// all outputs compared each cycle against a behavioural model of buffers and round pointers.
module tb_aes_keyram_nbuf_switch;

   logic         clk = 1'b0;
   logic         kill_n;
   logic         en_wr;
   logic [63:0]  key_round_wr;
   logic [1:0]   wr_buf;
   logic [1:0]   key_mode;
   logic         key_ready;
   logic         switch_key;
   logic [127:0] key_round_rd;
   logic [1:0]   key_idx;
   logic [3:0]   rd_round;
   logic         last_round;
   logic [3:0]   buf_valid;
   logic         wr_done;
   logic         wr_err;

   int n_cmp = 0;
   int n_bad = 0;

   aes_keyram_nbuf_switch dut (
      .clk          (clk),
      .kill_n       (kill_n),
      .en_wr        (en_wr),
      .key_round_wr (key_round_wr),
      .wr_buf       (wr_buf),
      .key_mode     (key_mode),
      .key_ready    (key_ready),
      .switch_key   (switch_key),
      .key_round_rd (key_round_rd),
      .key_idx      (key_idx),
      .rd_round     (rd_round),
      .last_round   (last_round),
      .buf_valid    (buf_valid),
      .wr_done      (wr_done),
      .wr_err       (wr_err)
   );

   always #5 clk = ~clk;

   // FIPS-197 AES-128 schedule for key 000102..0f, byte 0 in the least significant position.
   logic [127:0] fips_rk [11];

   // ---------------- behavioural model ----------------
   logic [63:0] mem_lo [4][15];
   logic [63:0] mem_hi [4][15];
   bit          kn_lo  [4][15];
   bit          kn_hi  [4][15];
   bit [3:0]    m_valid;
   int          m_mode [4];
   int          m_k, m_r;
   bit          m_loading, m_dropping;
   int          m_tgt, m_lmode, m_cnt;
   logic [127:0] e_rd;
   bit          e_rd_chk, e_done, e_err, e_last;

   function automatic int nrk_of(input int m);
      return (m == 1) ? 13 : ((m == 2) ? 15 : 11);
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic store(input int b, input int w, input logic [63:0] d);
      if (w % 2 == 0) begin mem_lo[b][w/2] = d; kn_lo[b][w/2] = 1; end
      else            begin mem_hi[b][w/2] = d; kn_hi[b][w/2] = 1; end
   endtask

   task automatic model_step();
      int k0; bit [3:0] v0; int t; bit found;
      if (!kill_n) begin
         m_valid = '0; m_k = 0; m_r = 0; m_loading = 0; m_dropping = 0; m_cnt = 0;
         for (int i = 0; i < 4; i++) m_mode[i] = 0;
         e_rd = '0; e_rd_chk = 1; e_done = 0; e_err = 0; e_last = 0;
         return;
      end
      // Registered read reflects the pointers and contents before this edge.
      e_rd_chk = kn_lo[m_k][m_r] && kn_hi[m_k][m_r];
      e_rd     = {mem_hi[m_k][m_r], mem_lo[m_k][m_r]};
      k0 = m_k; v0 = m_valid; e_done = 0; e_err = 0;
      if (switch_key) begin
         found = 0; t = k0;
         for (int j = 1; j < 4; j++)
            if (!found && v0[(k0 + j) % 4]) begin found = 1; t = (k0 + j) % 4; end
         if (found) begin m_k = t; m_r = 0; m_valid[k0] = 0; end
      end else if (key_ready) begin
         m_r = (m_r >= nrk_of(m_mode[k0]) - 1) ? 0 : m_r + 1;
      end
      if (en_wr) begin
         if (!m_loading && !m_dropping) begin
            m_tgt = int'(wr_buf); m_lmode = (key_mode == 2'd3) ? 0 : int'(key_mode); m_cnt = 1;
            if (m_tgt == k0 && v0[k0]) begin
               m_dropping = 1; e_err = 1;
            end else begin
               m_valid[m_tgt] = 0;
               for (int r = 0; r < 15; r++) begin kn_lo[m_tgt][r] = 0; kn_hi[m_tgt][r] = 0; end
               store(m_tgt, 0, key_round_wr);
               m_loading = 1;
            end
         end else if (m_loading) begin
            store(m_tgt, m_cnt, key_round_wr);
            m_cnt++;
            if (m_cnt == 2 * nrk_of(m_lmode)) begin
               m_loading = 0; m_valid[m_tgt] = 1; m_mode[m_tgt] = m_lmode; e_done = 1;
            end
         end else begin
            m_cnt++;
            if (m_cnt == 2 * nrk_of(m_lmode)) m_dropping = 0;
         end
      end
      e_last = (m_r == nrk_of(m_mode[m_k]) - 1);
   endtask

   task automatic compare();
      if (e_rd_chk) chk("key_round_rd", key_round_rd, e_rd);
      chk("key_idx",    128'(key_idx),    128'(m_k));
      chk("rd_round",   128'(rd_round),   128'(m_r));
      chk("last_round", 128'(last_round), 128'(e_last));
      chk("buf_valid",  128'(buf_valid),  128'(m_valid));
      chk("wr_done",    128'(wr_done),    128'(e_done));
      chk("wr_err",     128'(wr_err),     128'(e_err));
   endtask

   always @(posedge clk) begin
      model_step();
      #1;
      compare();
   end

   // ---------------- stimulus ----------------
   task automatic next();
      @(negedge clk);
   endtask

   task automatic load(input int b, input int m, input bit fips, input int gap_pct,
                       input int rdy_pct, input int stop_at,
                       output bit saw_done, output bit saw_err);
      int n;
      n = 2 * nrk_of(m);
      saw_done = 0; saw_err = 0;
      for (int w = 0; w < n; w++) begin
         if (w > 0 && int'($urandom_range(99)) < gap_pct) begin
            en_wr = 0; key_ready = (int'($urandom_range(99)) < rdy_pct);
            next();
            saw_done |= wr_done; saw_err |= wr_err;
         end
         if (stop_at != 0 && w == stop_at) begin en_wr = 0; key_ready = 0; return; end
         en_wr    = 1;
         wr_buf   = (w == 0) ? 2'(b) : 2'($urandom);
         key_mode = (w == 0) ? 2'(m) : 2'($urandom);
         if (fips) key_round_wr = (w % 2 == 1) ? fips_rk[w/2][127:64] : fips_rk[w/2][63:0];
         else      key_round_wr = {$urandom, $urandom};
         key_ready = (int'($urandom_range(99)) < rdy_pct);
         next();
         saw_done |= wr_done; saw_err |= wr_err;
      end
      en_wr = 0; key_ready = 0;
   endtask

   task automatic pulses(input int n);
      key_ready = 1;
      repeat (n) next();
      key_ready = 0;
   endtask

   task automatic do_switch();
      switch_key = 1; next(); switch_key = 0;
   endtask

   initial begin
      bit sd, se;
      fips_rk[0]  = 128'h0f0e0d0c0b0a09080706050403020100;
      fips_rk[1]  = 128'hfe76abd6f178a6dafa72afd2fd74aad6;
      fips_rk[2]  = 128'hfeb3326800c59bbef1bd3d640bcf92b6;
      fips_rk[3]  = 128'h41bf6904bf0c596cbfc9c2d24e74ffb6;
      fips_rk[4]  = 128'hfd8d05fdbc326cf9033e3595bcf7f747;
      fips_rk[5]  = 128'haa22f6ad57aff350eb9d9fa9e8a3aa3c;
      fips_rk[6]  = 128'h6b1fa30ac13d55a79692a6f77d0f395e;
      fips_rk[7]  = 128'h26c0a94e4ddf0a448ce25fe31a70f914;
      fips_rk[8]  = 128'hd27abfaef4ba16e0b9651ca435874347;
      fips_rk[9]  = 128'h4e972cbe9ced9310685785f0d1329954;
      fips_rk[10] = 128'hc5302b4d8ba707f3174a94e37f1d1113;
      for (int b = 0; b < 4; b++)
         for (int r = 0; r < 15; r++) begin kn_lo[b][r] = 0; kn_hi[b][r] = 0; end

      kill_n = 0; en_wr = 0; key_round_wr = '0; wr_buf = '0; key_mode = '0;
      key_ready = 0; switch_key = 0;
      repeat (3) next();
      chk("rst_key_round_rd", key_round_rd, 128'h0);
      chk("rst_key_idx",    128'(key_idx),    128'h0);
      chk("rst_rd_round",   128'(rd_round),   128'h0);
      chk("rst_buf_valid",  128'(buf_valid),  128'h0);
      chk("rst_last_round", 128'(last_round), 128'h0);
      chk("rst_wr_done",    128'(wr_done),    128'h0);
      kill_n = 1;
      next();

      // AES-128 FIPS key into buf 0
      load(0, 0, 1, 0, 0, 0, sd, se);
      chk("ld0_wr_done",   128'(wr_done),   128'h1);
      chk("ld0_buf_valid", 128'(buf_valid), 128'h1);
      next();
      chk("ld0_rk0", key_round_rd, 128'h0f0e0d0c0b0a09080706050403020100);
      pulses(1);
      next();
      chk("ld0_rk1_idx", 128'(rd_round), 128'h1);
      chk("ld0_rk1", key_round_rd, 128'hfe76abd6f178a6dafa72afd2fd74aad6);
      pulses(9);
      chk("ld0_last_at10", 128'(last_round), 128'h1);
      chk("ld0_rd10", 128'(rd_round), 128'd10);
      next();
      chk("ld0_rk10", key_round_rd, 128'hc5302b4d8ba707f3174a94e37f1d1113);
      pulses(1);
      chk("ld0_wrap", 128'(rd_round), 128'h0);
      chk("ld0_wrap_last", 128'(last_round), 128'h0);

      // buf 1 with gaps while buf 0 is read, then switch
      load(1, 0, 0, 30, 50, 0, sd, se);
      chk("ld1_done_seen", 128'(sd), 128'h1);
      next();
      do_switch();
      chk("sw1_key_idx",   128'(key_idx),   128'h1);
      chk("sw1_rd_round",  128'(rd_round),  128'h0);
      chk("sw1_buf_valid", 128'(buf_valid), 128'h2);

      // reload of the active, valid buffer is dropped
      load(1, 0, 0, 20, 0, 0, sd, se);
      chk("drop_err_seen",  128'(se), 128'h1);
      chk("drop_no_done",   128'(sd), 128'h0);
      chk("drop_buf_valid", 128'(buf_valid), 128'h2);
      pulses(11);
      next();

      // AES-256 into buf 2, AES-192 into buf 3
      load(2, 2, 0, 10, 30, 0, sd, se);
      load(3, 1, 0, 10, 30, 0, sd, se);
      next();
      chk("ld23_buf_valid", 128'(buf_valid), 128'he);
      do_switch();
      chk("sw2_key_idx", 128'(key_idx), 128'h2);
      pulses(14);
      chk("aes256_rd14",   128'(rd_round),   128'd14);
      chk("aes256_last",   128'(last_round), 128'h1);
      do_switch();
      chk("sw3_key_idx", 128'(key_idx), 128'h3);
      pulses(12);
      chk("aes192_rd12",   128'(rd_round),   128'd12);
      chk("aes192_last",   128'(last_round), 128'h1);
      do_switch();
      chk("sw_none_key_idx",  128'(key_idx),  128'h3);
      chk("sw_none_rd_round", 128'(rd_round), 128'd12);

      // reset in the middle of a load
      load(1, 0, 0, 0, 0, 10, sd, se);
      kill_n = 0;
      next();
      chk("kill_key_round_rd", key_round_rd, 128'h0);
      chk("kill_key_idx",   128'(key_idx),   128'h0);
      chk("kill_rd_round",  128'(rd_round),  128'h0);
      chk("kill_buf_valid", 128'(buf_valid), 128'h0);
      kill_n = 1;
      next();
      load(1, 0, 1, 0, 0, 0, sd, se);
      chk("reld1_done",      128'(wr_done),   128'h1);
      chk("reld1_buf_valid", 128'(buf_valid), 128'h2);
      do_switch();
      chk("reld1_key_idx", 128'(key_idx), 128'h1);
      next();
      chk("reld1_rk0", key_round_rd, 128'h0f0e0d0c0b0a09080706050403020100);

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         en_wr        = (int'($urandom_range(99)) < 60);
         wr_buf       = 2'($urandom);
         key_mode     = 2'($urandom);
         key_round_wr = {$urandom, $urandom};
         key_ready    = (int'($urandom_range(99)) < 40);
         switch_key   = (int'($urandom_range(99)) < 8);
         kill_n       = ($urandom_range(999) != 0);
         next();
      end
      kill_n = 1; en_wr = 0; key_ready = 0; switch_key = 0;
      next();
      next();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/aes_keyram_nbuf_switch.md
Name: aes_keyram_nbuf_switch

Overview:
Parametrised round-key store for the AES cores, generalising the two-buffer 128-bit key RAM to NUM_BUF buffers and AES-128/192/256 key schedules. The key-expansion side writes round keys as 64-bit beats into a free buffer. The cipher datapath reads one 128-bit round key per round from the active buffer. switch_key moves the datapath to the next loaded buffer round-robin, so a new key can be loaded while the current one is in use.

Parameters:
NUM_BUF, 4, number of key buffers (power of 2, >=2)
BUF_AW, 2, buffer index width = clog2(NUM_BUF)
MAX_RK, 15, round keys per buffer (AES-256 worst case)

Ports:
clk  in  1  clock, rising edge
kill_n  in  1  asynchronous active-low reset
en_wr  in  1  write beat strobe
key_round_wr  in  64  write data; low half of a round key first, then high half
wr_buf  in  BUF_AW  target buffer; sampled on first beat of a load only
key_mode  in  2  00=AES-128, 01=AES-192, 10=AES-256, 11 treated as 00; sampled on first beat
key_ready  in  1  advance to next round key
switch_key  in  1  move to next valid buffer
key_round_rd  out  128  active round key {hi,lo}, registered
key_idx  out  BUF_AW  active buffer index
rd_round  out  4  active round-key index
last_round  out  1  rd_round == NRK-1 of active buffer
buf_valid  out  NUM_BUF  per-buffer loaded flag
wr_done  out  1  1-cycle pulse when a load completes
wr_err  out  1  1-cycle pulse when a load is rejected

Behaviour:
- Reset (async, kill_n=0):
  - All outputs 0; key_idx=0, rd_round=0, buf_valid=0.
  - Write FSM returns to IDLE; a load in progress is discarded.
  - RAM contents are not cleared.
- NRK (round keys per schedule) by mode: 11 / 13 / 15. Beats per load = 2*NRK (22 / 26 / 30).
- Write FSM states: IDLE, LOAD, DROP.
  - IDLE + en_wr: latch wr_buf and mode.
    - If wr_buf==key_idx and buf_valid[key_idx]=1: go to DROP, pulse wr_err, discard the beat.
    - Otherwise: clear buf_valid[wr_buf], store the beat as word 0, go to LOAD.
  - LOAD: each en_wr beat stores the next word. Gaps (en_wr=0) pause the load without aborting it. Word 2k is round key k low half; word 2k+1 is the high half.
  - Final beat: the next cycle sets buf_valid[target], stores the mode per buffer, pulses wr_done, and returns to IDLE.
  - DROP: count and discard beats up to 2*NRK, then return to IDLE; no wr_done.
  - wr_buf/key_mode changes mid-load are ignored.
- Read path:
  - key_round_rd = mem[key_idx][rd_round], synchronous read with 1-cycle latency after any index change.
  - key_ready: rd_round+1; at NRK-1 it wraps to 0.
  - key_ready while buf_valid[key_idx]=0: rd_round still advances; data is undefined.
- switch_key: search (key_idx+1 .. key_idx+NUM_BUF-1) mod NUM_BUF for the first valid buffer.
  - Found: key_idx <- it, rd_round <- 0, clear buf_valid of the old buffer (freed for reload).
  - None found: no change.
  - The search uses buf_valid before this cycle's update, so a load completing in the same cycle is not selected.
- switch_key and key_ready in the same cycle: switch wins and rd_round=0. key_ready is ignored even if no switch target exists.
- Loading the inactive buffer while reading the active one has no read-side effect.
- Loading into key_idx while it is invalid (e.g. first key after reset) is allowed; reads see new words as they are written.

Decomposition:
- Package aes_keyram_pkg:
  - key_mode_t enum (AES128/AES192/AES256)
  - nrk(mode) function
  - constants WR_W=64, RD_W=128, MAX_RK=15
- Sub-module aes_keyram_bank: simple dual-port sync-read RAM, 64-bit x NUM_BUF*MAX_RK.
  - Instantiated twice (lo bank, hi bank); word parity selects the bank.
- FSM, pointers and switch arbitration live in the top module.

Test Plan:
- Reset, load buf 0 in AES-128 with FIPS-197 key 000102..0f schedule (22 beats) -> wr_done at cycle after beat 22; buf_valid=0001.
  - key_round_rd = 0f0e0d0c0b0a09080706050403020100; after one key_ready: fe76abd6f178a6dafa72afd2fd74aad6.
- 11 key_ready pulses on buf 0 -> last_round high at rd_round=10 (c5302b4d8ba707f3_174a94e37f1d1113); 11th pulse wraps rd_round to 0.
- Load buf 1 with 22 beats containing en_wr gaps while issuing key_ready on buf 0 -> buf 0 reads unaffected.
  - Then switch_key -> key_idx=1, rd_round=0, buf_valid=0010.
- With buf 1 active and valid, start a load with wr_buf=1 -> wr_err pulse, 22 beats dropped, buf 1 data unchanged, no wr_done.
- AES-256 load (30 beats) into buf 2, AES-192 (26 beats) into buf 3, then switch twice -> last_round at rd_round 14, then at rd_round 12.
  - A further switch with no other valid buffer -> key_idx unchanged.
- Assert kill_n at beat 10 of a load into buf 1 -> all outputs 0, buf_valid=0.
  - A subsequent full load into buf 1 completes normally.
